// File: rtl/usb_fx2_slave_fifo_master.sv
// ---------------------------------------------------------------------------
// usb_fx2_slave_fifo_master
//
// Master for the Cypress FX2 synchronous slave-FIFO interface. It shares the
// fdata bus between host->FPGA reads (OUT endpoint RX_EP) and FPGA->host
// writes (IN endpoint TX_EP) using round-robin arbitration with a per-grant
// burst limit. Read data lands in a small RX FIFO so a stalled client never
// stalls the bus mid-word. Short IN packets are committed with PKTEND either
// on tx_last or after an idle timeout.
//
// Ports
//   clk48, nreset        IFCLK and asynchronous active-low reset
//   flaga, flagd         FX2 flags: RX_EP not empty / TX_EP not full
//   faddr                endpoint select
//   sloe, slrd, slwr     FX2 output enable / read / write strobes (active low)
//   pktend               FX2 packet end (active low)
//   fdata                bidirectional data bus, driven only in WR
//   tx_valid/ready/data/last   client TX stream (tx_last commits the packet)
//   rx_valid/ready/data        client RX stream (head of the RX FIFO)
//   rx_level             RX FIFO occupancy, 0..RX_DEPTH
// ---------------------------------------------------------------------------
module usb_fx2_slave_fifo_master #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned RX_DEPTH       = 4,
    parameter logic [1:0]  RX_EP          = 2'b00,
    parameter logic [1:0]  TX_EP          = 2'b10,
    parameter int unsigned BURST_MAX      = 64,
    parameter int unsigned PKTEND_TIMEOUT = 256
) (
    input  logic                      clk48,
    input  logic                      nreset,
    input  logic                      flaga,
    input  logic                      flagd,
    output logic [1:0]                faddr,
    output logic                      sloe,
    output logic                      slrd,
    output logic                      slwr,
    output logic                      pktend,
    inout  wire  [DATA_W-1:0]         fdata,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_last,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [DATA_W-1:0]         rx_data,
    output logic [$clog2(RX_DEPTH):0] rx_level
);

    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam int unsigned TW = (PKTEND_TIMEOUT > 32'd0) ? $clog2(PKTEND_TIMEOUT + 1) : 1;

    localparam logic [LW-1:0] RX_FULL_LVL = LW'(RX_DEPTH);
    localparam logic [BW-1:0] BURST_LIM   = BW'(BURST_MAX);
    localparam logic [TW-1:0] TMO_MAX     = TW'(PKTEND_TIMEOUT);
    localparam logic          TMO_EN      = (PKTEND_TIMEOUT != 32'd0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WR_TURN = 3'd2,
        ST_WR      = 3'd3,
        ST_PKT     = 3'd4
    } state_e;

    state_e              state_q;
    logic                last_grant_tx_q;
    logic [BW-1:0]       burst_q;
    logic                pending_q;
    logic [TW-1:0]       tmo_q;

    logic [DATA_W-1:0]   rx_mem_q [RX_DEPTH];
    logic [AW-1:0]       rx_wptr_q;
    logic [AW-1:0]       rx_rptr_q;
    logic [LW-1:0]       rx_level_q;

    logic rx_full_s;
    logic burst_ok_s;
    logic tmo_hit_s;
    logic rx_req_s;
    logic tx_req_s;
    logic rd_fire_s;
    logic wr_fire_s;
    logic rx_pop_s;

    assign rx_full_s  = (rx_level_q == RX_FULL_LVL);
    assign burst_ok_s = (burst_q < BURST_LIM);
    // A pending packet is auto-committed once the idle counter saturates.
    assign tmo_hit_s  = TMO_EN && pending_q && (tmo_q == TMO_MAX);
    assign rx_req_s   = flaga && !rx_full_s;
    assign tx_req_s   = tx_valid || tmo_hit_s;
    // Strobes are combinational so a word moves on the very edge the flag allows it.
    assign rd_fire_s  = (state_q == ST_RD) && rx_req_s && burst_ok_s;
    assign wr_fire_s  = (state_q == ST_WR) && tx_valid && flagd && burst_ok_s;
    assign rx_valid   = (rx_level_q != {LW{1'b0}});
    assign rx_pop_s   = rx_valid && rx_ready;

    assign faddr    = ((state_q == ST_IDLE) || (state_q == ST_RD)) ? RX_EP : TX_EP;
    assign sloe     = (state_q != ST_RD);
    assign slrd     = !rd_fire_s;
    assign slwr     = !wr_fire_s;
    assign tx_ready = wr_fire_s;
    assign pktend   = (state_q != ST_PKT);
    // Only WR drives the bus; WR_TURN gives the FX2 a cycle to release it.
    assign fdata    = (state_q == ST_WR) ? tx_data : {DATA_W{1'bz}};

    assign rx_data  = rx_mem_q[rx_rptr_q];
    assign rx_level = rx_level_q;

    // Arbitration FSM, burst counter, pending-packet flag and idle timeout.
    always_ff @(posedge clk48 or negedge nreset) begin
        if (!nreset) begin
            state_q         <= ST_IDLE;
            last_grant_tx_q <= 1'b1;
            burst_q         <= {BW{1'b0}};
            pending_q       <= 1'b0;
            tmo_q           <= {TW{1'b0}};
        end else begin
            if (wr_fire_s || (state_q == ST_PKT)) begin
                tmo_q <= {TW{1'b0}};
            end else if (TMO_EN && pending_q && (tmo_q != TMO_MAX)) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= tmo_q;
            end

            case (state_q)
                ST_IDLE: begin
                    // RX wins a tie only when TX had the previous grant.
                    if (rx_req_s && (!tx_req_s || last_grant_tx_q)) begin
                        state_q <= ST_RD;
                        burst_q <= {BW{1'b0}};
                    end else if (tx_req_s) begin
                        state_q <= ST_WR_TURN;
                        burst_q <= {BW{1'b0}};
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (rd_fire_s) begin
                        burst_q <= burst_q + BW'(1);
                    end else begin
                        state_q         <= ST_IDLE;
                        last_grant_tx_q <= 1'b0;
                    end
                end
                ST_WR_TURN: begin
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    if (wr_fire_s) begin
                        burst_q   <= burst_q + BW'(1);
                        pending_q <= 1'b1;
                        if (tx_last) begin
                            state_q <= ST_PKT;
                        end else begin
                            state_q <= ST_WR;
                        end
                    end else if (tmo_hit_s && !tx_valid) begin
                        state_q <= ST_PKT;
                    end else begin
                        state_q         <= ST_IDLE;
                        last_grant_tx_q <= 1'b1;
                    end
                end
                ST_PKT: begin
                    pending_q       <= 1'b0;
                    last_grant_tx_q <= 1'b1;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RX FIFO pointers and occupancy; a push never happens at full because
    // rx_full gates slrd.
    always_ff @(posedge clk48 or negedge nreset) begin
        if (!nreset) begin
            rx_wptr_q  <= {AW{1'b0}};
            rx_rptr_q  <= {AW{1'b0}};
            rx_level_q <= {LW{1'b0}};
        end else begin
            if (rd_fire_s) begin
                rx_wptr_q <= rx_wptr_q + AW'(1);
            end else begin
                rx_wptr_q <= rx_wptr_q;
            end
            if (rx_pop_s) begin
                rx_rptr_q <= rx_rptr_q + AW'(1);
            end else begin
                rx_rptr_q <= rx_rptr_q;
            end
            case ({rd_fire_s, rx_pop_s})
                2'b10:   rx_level_q <= rx_level_q + LW'(1);
                2'b01:   rx_level_q <= rx_level_q - LW'(1);
                default: rx_level_q <= rx_level_q;
            endcase
        end
    end

    // RX FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk48) begin
        if (rd_fire_s) begin
            rx_mem_q[rx_wptr_q] <= fdata;
        end
    end

endmodule
